// File: rtl/vga_plot_arbiter.sv
// Pixel-write port owner for the vga_adapter: round-robin arbitration between two
// valid/ready pixel requesters plus a full-screen clear engine.
module vga_plot_arbiter #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int C_W   = 3,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear_req,
    input  logic [C_W-1:0] clear_colour,
    input  logic           req0_valid,
    input  logic [X_W-1:0] req0_x,
    input  logic [Y_W-1:0] req0_y,
    input  logic [C_W-1:0] req0_colour,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [X_W-1:0] req1_x,
    input  logic [Y_W-1:0] req1_y,
    input  logic [C_W-1:0] req1_colour,
    output logic           req1_ready,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [C_W-1:0] colour,
    output logic           plot,
    output logic           busy,
    output logic           clear_done,
    output logic           oob_err
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [X_W-1:0] XMAX_C = X_W'(X_MAX);
    localparam logic [Y_W-1:0] YMAX_C = Y_W'(Y_MAX);

    logic [0:0]     state_q, state_d;
    logic           pend_q, pend_d;
    logic [C_W-1:0] ccol_q, ccol_d;
    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;
    logic           last_grant_q, last_grant_d;
    logic           xfer_q, xfer_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [C_W-1:0] col_q, col_d;
    logic           plot_q, plot_d;
    logic           done_q, done_d;
    logic           oob_q, oob_d;

    logic           busy_w;
    logic           xfer;
    logic [X_W-1:0] win_x;
    logic [Y_W-1:0] win_y;
    logic [C_W-1:0] win_col;

    function automatic logic in_range(input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
        return (px <= XMAX_C) && (py <= YMAX_C);
    endfunction

    assign busy_w = pend_q | (state_q == S_CLEAR);

    // Grants are suppressed while a clear is requested, pending or running.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset && !busy_w && !clear_req) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q) begin
                    req0_ready = 1'b1;
                end else begin
                    req1_ready = 1'b1;
                end
            end else if (req0_valid) begin
                req0_ready = 1'b1;
            end else if (req1_valid) begin
                req1_ready = 1'b1;
            end
        end
    end

    assign xfer    = req0_ready | req1_ready;
    assign win_x   = req1_ready ? req1_x      : req0_x;
    assign win_y   = req1_ready ? req1_y      : req0_y;
    assign win_col = req1_ready ? req1_colour : req0_colour;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        ccol_d       = ccol_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        last_grant_d = last_grant_q;
        xfer_d       = xfer;
        x_d          = x_q;
        y_d          = y_q;
        col_d        = col_q;
        plot_d       = 1'b0;
        done_d       = 1'b0;
        oob_d        = oob_q;

        if (xfer) begin
            last_grant_d = req1_ready;
            if (in_range(win_x, win_y)) begin
                x_d    = win_x;
                y_d    = win_y;
                col_d  = win_col;
                plot_d = 1'b1;
            end else begin
                oob_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                // A pixel already plotting this cycle defers the clear by one cycle.
                if (clear_req && !busy_w) begin
                    ccol_d = clear_colour;
                    if (xfer_q) begin
                        pend_d = 1'b1;
                    end else begin
                        state_d = S_CLEAR;
                        cx_d    = '0;
                        cy_d    = '0;
                        x_d     = '0;
                        y_d     = '0;
                        col_d   = clear_colour;
                        plot_d  = 1'b1;
                    end
                end else if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = S_CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                    x_d     = '0;
                    y_d     = '0;
                    col_d   = ccol_q;
                    plot_d  = 1'b1;
                end
            end
            S_CLEAR: begin
                if ((cx_q == XMAX_C) && (cy_q == YMAX_C)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    if (cx_q == XMAX_C) begin
                        cx_d = '0;
                        cy_d = cy_q + Y_W'(1);
                    end else begin
                        cx_d = cx_q + X_W'(1);
                    end
                    x_d    = cx_d;
                    y_d    = cy_d;
                    col_d  = ccol_q;
                    plot_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pend_q       <= 1'b0;
            ccol_q       <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            last_grant_q <= 1'b1;
            xfer_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            col_q        <= '0;
            plot_q       <= 1'b0;
            done_q       <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            ccol_q       <= ccol_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            last_grant_q <= last_grant_d;
            xfer_q       <= xfer_d;
            x_q          <= x_d;
            y_q          <= y_d;
            col_q        <= col_d;
            plot_q       <= plot_d;
            done_q       <= done_d;
            oob_q        <= oob_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = col_q;
    assign plot       = plot_q;
    assign busy       = busy_w;
    assign clear_done = done_q;
    assign oob_err    = oob_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: a pixel-index model checked every cycle plus
// literal expectations for the headline scenarios.
module tb_vga_plot_arbiter;

    localparam int W = 160;
    localparam int H = 120;
    localparam int NPIX = W * H;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear_req;
    logic [2:0] clear_colour;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_x, req1_x;
    logic [6:0] req0_y, req1_y;
    logic [2:0] req0_colour, req1_colour;
    logic       req0_ready, req1_ready;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, clear_done, oob_err;

    int n_vec = 0;
    int n_err = 0;

    vga_plot_arbiter dut (
        .clock(clock), .reset(reset), .clear_req(clear_req), .clear_colour(clear_colour),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_colour(req0_colour),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_colour(req1_colour),
        .req1_ready(req1_ready),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
        .clear_done(clear_done), .oob_err(oob_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: what the pixel port must show in the current cycle.
    bit m_on = 0;
    int m_plot, m_x, m_y, m_col, m_done, m_oob, m_last, m_xprev;
    bit m_clearing, m_pend;
    int m_k, m_ccol;

    task automatic m_start();
        m_clearing = 1; m_pend = 0; m_k = 0;
        m_x = 0; m_y = 0; m_col = m_ccol; m_plot = 1;
    endtask

    always @(negedge clock) begin
        int e_r0, e_r1, mbusy, g, px, py, pc;
        mbusy = (m_pend || m_clearing) ? 1 : 0;
        e_r0 = 0; e_r1 = 0;
        if (!reset && !mbusy && !clear_req) begin
            if (req0_valid && req1_valid) begin
                if (m_last == 1) e_r0 = 1; else e_r1 = 1;
            end else if (req0_valid) e_r0 = 1;
            else if (req1_valid) e_r1 = 1;
        end
        if (m_on) begin
            chk("m_plot", plot, m_plot);
            chk("m_busy", busy, mbusy);
            chk("m_done", clear_done, m_done);
            chk("m_oob", oob_err, m_oob);
            chk("m_ready0", req0_ready, e_r0);
            chk("m_ready1", req1_ready, e_r1);
            if (m_plot == 1) begin
                chk("m_x", x, m_x);
                chk("m_y", y, m_y);
                chk("m_colour", colour, m_col);
            end
        end
        if (reset) begin
            m_on = 1; m_plot = 0; m_x = 0; m_y = 0; m_col = 0; m_done = 0; m_oob = 0;
            m_last = 1; m_xprev = 0; m_clearing = 0; m_pend = 0; m_k = 0; m_ccol = 0;
        end else if (m_on) begin
            m_plot = 0;
            m_done = 0;
            if (e_r0 || e_r1) begin
                g  = e_r1;
                px = g ? int'(req1_x) : int'(req0_x);
                py = g ? int'(req1_y) : int'(req0_y);
                pc = g ? int'(req1_colour) : int'(req0_colour);
                m_last = g;
                if (px < W && py < H) begin
                    m_x = px; m_y = py; m_col = pc; m_plot = 1;
                end else begin
                    m_oob = 1;
                end
            end
            if (m_clearing) begin
                if (m_k == NPIX - 1) begin
                    m_clearing = 0; m_done = 1;
                end else begin
                    m_k++;
                    m_x = m_k % W; m_y = m_k / W; m_col = m_ccol; m_plot = 1;
                end
            end else if (clear_req && !mbusy) begin
                m_ccol = int'(clear_colour);
                if (m_xprev == 1) m_pend = 1; else m_start();
            end else if (m_pend) begin
                m_start();
            end
            m_xprev = (e_r0 || e_r1) ? 1 : 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int cnt, bad, lastx, lasty, done_n;
        bit done_seen, pulsed;
        reset = 1; clear_req = 0; clear_colour = 0;
        req0_valid = 0; req0_x = 0; req0_y = 0; req0_colour = 0;
        req1_valid = 0; req1_x = 0; req1_y = 0; req1_colour = 0;
        repeat (3) tick();
        reset = 0;
        @(negedge clock);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_oob", oob_err, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);

        // Single pixel from requester 0.
        tick();
        req0_valid = 1; req0_x = 10; req0_y = 20; req0_colour = 3'b101;
        @(negedge clock);
        chk("p1_ready0", req0_ready, 1);
        chk("p1_ready1", req1_ready, 0);
        tick();
        req0_valid = 0;
        @(negedge clock);
        chk("p1_plot", plot, 1);
        chk("p1_x", x, 10);
        chk("p1_y", y, 20);
        chk("p1_colour", colour, 5);
        tick();
        @(negedge clock);
        chk("p1_plot_after", plot, 0);

        // Round-robin from a fresh reset.
        tick();
        reset = 1;
        tick();
        reset = 0;
        req0_valid = 1; req0_x = 1; req0_y = 2; req0_colour = 1;
        req1_valid = 1; req1_x = 3; req1_y = 4; req1_colour = 6;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clock);
        chk("rr_last_plot", plot, 1);
        chk("rr_last_x", x, 3);
        repeat (3) tick();

        // Full clear in colour 2 with requester 0 waiting and a stray clear_req at pixel 500.
        clear_req = 1; clear_colour = 3'b010;
        req0_valid = 1; req0_x = 50; req0_y = 60; req0_colour = 7;
        @(negedge clock);
        chk("clr_req_ready0", req0_ready, 0);
        chk("clr_req_busy", busy, 0);
        tick();
        clear_req = 0;
        cnt = 0; bad = 0; lastx = -1; lasty = -1; done_n = 0; done_seen = 0; pulsed = 0;
        for (int c = 0; c < NPIX + 200; c++) begin
            @(negedge clock);
            if (clear_done) begin
                done_n++; done_seen = 1;
                chk("clr_done_plot", plot, 0);
                chk("clr_done_busy", busy, 0);
            end else if (plot) begin
                if (cnt == 0) begin
                    chk("clr_first_x", x, 0);
                    chk("clr_first_y", y, 0);
                end
                cnt++;
                if (colour != 3'd2) bad++;
                lastx = x; lasty = y;
            end
            tick();
            clear_req = 0;
            if (cnt == 500 && !pulsed) begin
                clear_req = 1; clear_colour = 3'd7; pulsed = 1;
            end
            if (done_seen) break;
        end
        chk("clr_done_seen", done_seen, 1);
        chk("clr_done_count", done_n, 1);
        chk("clr_plot_count", cnt, NPIX);
        chk("clr_bad_colour", bad, 0);
        chk("clr_last_x", lastx, 159);
        chk("clr_last_y", lasty, 119);
        req0_valid = 0;
        repeat (2) tick();

        // Out-of-range pixels from requester 1.
        req1_valid = 1; req1_x = 160; req1_y = 5; req1_colour = 1;
        tick();
        req1_x = 3; req1_y = 120;
        @(negedge clock);
        chk("oob_plot0", plot, 0);
        chk("oob_flag0", oob_err, 1);
        tick();
        req1_x = 3; req1_y = 5; req1_colour = 4;
        tick();
        req1_valid = 0;
        @(negedge clock);
        chk("oob_ok_plot", plot, 1);
        chk("oob_ok_x", x, 3);
        chk("oob_ok_y", y, 5);
        chk("oob_ok_colour", colour, 4);
        tick();
        @(negedge clock);
        chk("oob_sticky", oob_err, 1);

        // Reset in the middle of a sweep.
        tick();
        clear_req = 1; clear_colour = 3;
        tick();
        clear_req = 0;
        cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            if (plot) cnt++;
            if (cnt == 1000) break;
            tick();
        end
        chk("abort_reached", cnt, 1000);
        tick();
        reset = 1;
        tick();
        reset = 0;
        @(negedge clock);
        chk("abort_plot", plot, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", clear_done, 0);
        chk("abort_oob", oob_err, 0);

        // Restart right behind a transfer: the clear waits for the pixel to land.
        tick();
        req0_valid = 1; req0_x = 7; req0_y = 8; req0_colour = 1;
        tick();
        req0_valid = 0; clear_req = 1; clear_colour = 6;
        @(negedge clock);
        chk("defer_xfer_plot", plot, 1);
        chk("defer_xfer_x", x, 7);
        tick();
        clear_req = 0;
        @(negedge clock);
        chk("defer_busy", busy, 1);
        chk("defer_gap_plot", plot, 0);
        tick();
        @(negedge clock);
        chk("restart_plot", plot, 1);
        chk("restart_x", x, 0);
        chk("restart_y", y, 0);
        chk("restart_colour", colour, 6);
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Owns the single pixel-write port (x, y, colour, plot) of the vga_adapter framebuffer.
- Shares that port between two pixel requesters (e.g. sprite drawer, score/text drawer) using valid/ready handshakes and round-robin arbitration.
- Contains a built-in clear engine that sweeps the whole 160x120 screen in one colour on request, used by the screen FSM on title/game transitions.

Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- C_W, 3, colour width
- X_MAX, 159, last valid column
- Y_MAX, 119, last valid row

Ports:
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- clear_req  in  1  single-cycle request to clear the screen
- clear_colour  in  C_W  fill colour; sampled when clear_req is accepted
- req0_valid  in  1  requester 0 has a pixel
- req0_x / req0_y / req0_colour  in  X_W / Y_W / C_W  requester 0 pixel
- req0_ready  out  1  requester 0 pixel accepted this cycle
- req1_valid  in  1  requester 1 has a pixel
- req1_x / req1_y / req1_colour  in  X_W / Y_W / C_W  requester 1 pixel
- req1_ready  out  1  requester 1 pixel accepted this cycle
- x  out  X_W  to vga_adapter
- y  out  Y_W  to vga_adapter
- colour  out  C_W  to vga_adapter
- plot  out  1  write strobe to vga_adapter
- busy  out  1  clear pending or in progress
- clear_done  out  1  one-cycle pulse when the clear completes
- oob_err  out  1  sticky flag: an out-of-range pixel was dropped

Behaviour:
- Reset values:
  - x, y, colour, plot, busy, clear_done, oob_err = 0
  - req0_ready, req1_ready = 0
  - FSM = IDLE
  - last_grant = 1, so req0 wins the first tie
  - Reset mid-clear aborts the sweep immediately; clear_done does not pulse.
- States:
  - IDLE/SERVE: serve requesters; stay here while clear_pend = 0.
  - CLEAR: sweep the screen.
- Clear request:
  - clear_req = 1 in IDLE sets clear_pend and latches clear_colour.
  - busy = clear_pend | (state == CLEAR).
  - clear_req while busy is ignored; the colour latch is not updated.
- Readies:
  - Both readies are 0 whenever busy = 1, including the cycle clear_req is sampled.
  - Readies are combinational from the valid inputs, busy and last_grant.
- Arbitration (not busy):
  - Only one valid: that requester gets ready.
  - Both valid: the requester != last_grant gets ready.
  - last_grant updates on every transfer (valid & ready).
  - At most one ready per cycle.
- Transfer timing:
  - A transfer in cycle N drives x/y/colour from the winner and plot = 1 in cycle N+1 (1-cycle latency).
  - With no transfer, plot = 0 and x/y/colour hold their last value.
- Out of range (x > X_MAX or y > Y_MAX):
  - The pixel is still accepted (ready = 1).
  - plot stays 0 in N+1; oob_err sets and stays set until reset.
- Entering CLEAR: the cycle after clear_pend is set, go to CLEAR with internal counters cx = 0, cy = 0.
- CLEAR sweep:
  - Each cycle outputs x = cx, y = cy, colour = latched colour, plot = 1.
  - cx increments and wraps at X_MAX to 0, then cy increments.
  - Exactly (X_MAX+1)*(Y_MAX+1) = 19200 consecutive plot cycles.
  - The first plot of the clear is the cycle after clear_req.
- Clear completion:
  - After the plot of (X_MAX, Y_MAX), the next cycle has clear_done = 1, plot = 0, busy = 0, state IDLE, clear_pend = 0.
  - Requesters may be granted in that same cycle.
- Clear racing a transfer: a transfer accepted in the cycle before clear_req still plots in the following cycle. That cycle is the first clear cycle, and the clear pixel (0,0) has priority. Therefore clear_req is only accepted when no transfer is in flight; otherwise it is deferred one cycle (clear_pend set one cycle later).
- Arithmetic: counters are X_W/Y_W wide with an explicit compare to X_MAX/Y_MAX; no reliance on natural wrap.

Test Plan:
- Reset, then req0_valid = 1 with (10, 20, 3b101), req1 idle -> req0_ready = 1 in the same cycle; the next cycle has plot = 1, x = 10, y = 20, colour = 5; the cycle after has plot = 0.
- Both requesters held valid for 4 cycles -> grants 0, 1, 0, 1; plot pulses on 4 consecutive cycles carrying the matching coordinates.
- clear_req with clear_colour = 3b010 from IDLE -> busy = 1 and readies = 0 throughout; 19200 plot cycles, first (0,0), last (159,119), all colour 2; clear_done pulses once the cycle after the last plot.
- clear_req pulsed again at sweep pixel 500 with colour 7 -> ignored; the sweep finishes with colour 2 and a total count of 19200.
- req1 sends (160, 5) then (3, 120) -> both accepted, no plot, oob_err = 1 and stays set; a following valid pixel (3, 5) plots normally.
- Reset asserted at sweep pixel 1000 -> plot = 0 and busy = 0 the next cycle, no clear_done; a new clear restarts at (0,0).
